// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state codes, character
// width, and helpers for mid-bit sample index and the oversample divider.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned ST_W      = 3;

  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;

  // Centre sample index within one bit period.
  function automatic int unsigned mid_sample(input int unsigned os);
    return os / 2;
  endfunction

  // Rounded clocks per oversample tick, never below 1.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    int unsigned den;
    int unsigned q;
    den = baud * os;
    q   = (clk_hz + den / 2) / den;
    return (q == 0) ? 1 : q;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO with full-drop and sticky overrun.
// DEPTH must be a power of two, at least 2.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             overrun,
  output logic [CW-1:0]    count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovr_q, ovr_d;
  logic             full_c, empty_c, do_pop_c, do_push_c;

  // Pointer, count and overrun update; a push into a full FIFO only lands
  // when the head leaves in the same cycle.
  always_comb begin
    mem_d     = mem_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    ovr_d     = ovr_q;
    full_c    = (cnt_q == CW'(DEPTH));
    empty_c   = (cnt_q == '0);
    do_pop_c  = !empty_c && pop_ready;
    do_push_c = push && (!full_c || do_pop_c);

    if (do_push_c) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + AW'(1);
    end
    if (do_pop_c) begin
      rd_d = rd_q + AW'(1);
    end
    if (push && full_c && !do_pop_c) begin
      ovr_d = 1'b1;
    end
    case ({do_push_c, do_pop_c})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage and control registers, synchronously cleared.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovr_q <= ovr_d;
    end
  end

  assign head    = mem_q[rd_q];
  assign valid   = (cnt_q != '0);
  assign overrun = ovr_q;
  assign count   = cnt_q;

endmodule

// File: rtl/uart_rx_framer.sv
// UART receiver: oversampled start detection, majority-vote bit sampling,
// LSB-first deframing and a FWFT byte FIFO.
// Optional macro UART_RX_PARITY_EN selects 8E1 framing and adds parity_err;
// without it the framing is 8N1.
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                        RST_clk,
  input  logic                        RST_n,
  input  logic                        uart_rx_data,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic                        frame_err,
  output logic                        overrun,
  output logic                        uart_busy,
`ifdef UART_RX_PARITY_EN
  output logic                        parity_err,
`endif
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned DIV   = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SMP_W = $clog2(OVERSAMPLE);
  localparam int unsigned MID   = mid_sample(OVERSAMPLE);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);

  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic                 prev_q, prev_d;
  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [SMP_W-1:0]     smp_q, smp_d;
  logic                 s_lo_q, s_lo_d;
  logic                 s_mid_q, s_mid_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 busy_q, busy_d;
  logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 perr_q, perr_d;
`endif

  logic fall_c, maj_c, tick_c, mid_c, end_c, push_c;

  // Two-flop synchronizer plus a delayed copy for edge detection.
  always_comb begin
    sync1_d = uart_rx_data;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  assign fall_c = prev_q & ~sync2_q;
  // Vote across the samples just before, at and after mid-bit.
  assign maj_c  = (s_lo_q & s_mid_q) | (s_lo_q & sync2_q) | (s_mid_q & sync2_q);

  // Tick/sample timing and the receive FSM.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    smp_d   = smp_q;
    s_lo_d  = s_lo_q;
    s_mid_d = s_mid_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    busy_d  = busy_q;
    ferr_d  = 1'b0;
    push_c  = 1'b0;
    tick_c  = 1'b0;
    mid_c   = 1'b0;
    end_c   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif

    if (state_q == ST_IDLE) begin
      div_d = '0;
      smp_d = '0;
      if (fall_c) begin
        state_d = ST_START;
        busy_d  = 1'b1;
        bit_d   = '0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = 1'b0;
`endif
      end
    end else begin
      if (div_q == DIV_W'(DIV - 1)) begin
        div_d  = '0;
        tick_c = 1'b1;
      end else begin
        div_d = div_q + DIV_W'(1);
      end

      if (tick_c) begin
        smp_d = (smp_q == SMP_W'(OVERSAMPLE - 1)) ? '0 : smp_q + SMP_W'(1);
        if (smp_q == SMP_W'(MID - 1)) s_lo_d  = sync2_q;
        if (smp_q == SMP_W'(MID))     s_mid_d = sync2_q;
        mid_c = (smp_q == SMP_W'(MID + 1));
        end_c = (smp_q == SMP_W'(OVERSAMPLE - 1));
      end

      case (state_q)
        ST_START: begin
          if (mid_c && maj_c) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else if (end_c) begin
            state_d = ST_DATA;
            bit_d   = '0;
          end
        end
        ST_DATA: begin
          if (mid_c) begin
            sh_d = {maj_c, sh_q[DATA_BITS-1:1]};
          end
          if (end_c) begin
            if (bit_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
              bit_d = '0;
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (mid_c) begin
            par_bad_d = (^sh_q) ^ maj_c;
            perr_d    = (^sh_q) ^ maj_c;
          end
          if (end_c) begin
            state_d = ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          // Decide at mid-stop and leave at once to absorb negative skew.
          if (mid_c) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            if (maj_c) begin
`ifdef UART_RX_PARITY_EN
              push_c = !par_bad_q;
`else
              push_c = 1'b1;
`endif
            end else begin
              ferr_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // Framer registers, synchronously reset; line flops idle high.
  always_ff @(posedge RST_clk) begin
    if (!RST_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= ST_IDLE;
      div_q   <= '0;
      smp_q   <= '0;
      s_lo_q  <= 1'b1;
      s_mid_q <= 1'b1;
      bit_q   <= '0;
      sh_q    <= '0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      div_q   <= div_d;
      smp_q   <= smp_d;
      s_lo_q  <= s_lo_d;
      s_mid_q <= s_mid_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      busy_q  <= busy_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign uart_busy = busy_q;
  assign frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (RST_clk),
    .rst_n     (RST_n),
    .push      (push_c),
    .push_data (sh_q),
    .pop_ready (rx_ready),
    .head      (rx_data),
    .valid     (rx_valid),
    .overrun   (overrun),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_uart_rx_framer.sv
// Self-checking bench for uart_rx_framer (CLK_HZ=18432000, BAUD=115200,
// OVERSAMPLE=16 -> 160 clocks per bit). Honours UART_RX_PARITY_EN.
module tb_uart_rx_framer;

  localparam int CLK_HZ = 18432000;
  localparam int BAUD   = 115200;
  localparam int OS     = 16;
  localparam int DEPTH  = 8;
  localparam int DIV    = (CLK_HZ + (BAUD * OS) / 2) / (BAUD * OS);
  localparam int BIT    = DIV * OS;
  localparam int M      = OS / 2;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // Bits before the stop bit: start + data (+ parity).
  localparam int NB = 1 + 8 + PB;
  // Busy lasts until the tick that completes the mid-bit vote (index M+1,
  // numbered from 0), every tick closing a DIV-clock period.
  localparam int BUSY_FRAME = DIV * (OS * NB + M + 2);
  localparam int BUSY_FALSE = DIV * (M + 2);

  logic       clk = 1'b0;
  logic       RST_n;
  logic       line;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       uart_busy;
  logic [3:0] fifo_count;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  always #5 clk = ~clk;

  uart_rx_framer #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .RST_clk      (clk),
    .RST_n        (RST_n),
    .uart_rx_data (line),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .frame_err    (frame_err),
    .overrun      (overrun),
    .uart_busy    (uart_busy),
`ifdef UART_RX_PARITY_EN
    .parity_err   (parity_err),
`endif
    .fifo_count   (fifo_count)
  );

  // Monitor: sampled on the falling edge, between input updates.
  logic [7:0] got_mem [256];
  int got_n       = 0;
  int valid_hi_n  = 0;
  int ferr_n      = 0;
  int perr_n      = 0;
  int busy_run    = 0;
  int busy_len    = 0;
  int busy_starts = 0;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) begin
      got_mem[got_n[7:0]] <= rx_data;
      got_n <= got_n + 1;
    end
    if (rx_valid) valid_hi_n <= valid_hi_n + 1;
    if (frame_err) ferr_n <= ferr_n + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err) perr_n <= perr_n + 1;
`endif
    if (uart_busy) begin
      if (busy_run == 0) busy_starts <= busy_starts + 1;
      busy_run <= busy_run + 1;
    end else if (busy_run != 0) begin
      busy_len <= busy_run;
      busy_run <= 0;
    end
  end

  // Reference model: queue of stored bytes and expected popped bytes.
  logic [7:0] mfifo[$];
  logic [7:0] mpop[$];
  logic       m_ovr = 1'b0;
  int         rd_i  = 0;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic good_frame(input logic [7:0] b, input logic stop_b, input logic par_b);
    return stop_b && ((PB == 0) || (((^b) ^ par_b) == 1'b0));
  endfunction

  task automatic model_frame(input logic [7:0] b, input logic stop_b, input logic par_b);
    if (good_frame(b, stop_b, par_b)) begin
      if (mfifo.size() < DEPTH) mfifo.push_back(b);
      else m_ovr = 1'b1;
    end
  endtask

  task automatic model_pop();
    if (mfifo.size() > 0) mpop.push_back(mfifo.pop_front());
  endtask

  task automatic model_drain();
    while (mfifo.size() > 0) mpop.push_back(mfifo.pop_front());
  endtask

  task automatic check_pops(input string tag);
    check({tag, "_npop"}, 32'(got_n - rd_i), 32'(mpop.size()));
    while (rd_i < got_n && mpop.size() > 0) begin
      check(tag, 32'(got_mem[rd_i[7:0]]), 32'(mpop.pop_front()));
      rd_i++;
    end
    mpop.delete();
    rd_i = got_n;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_b, input logic par_b, input int gap);
    line = 1'b0;
    repeat (BIT) step();
    for (int i = 0; i < 8; i++) begin
      line = b[i];
      repeat (BIT) step();
    end
    if (PB == 1) begin
      line = par_b;
      repeat (BIT) step();
    end
    line = stop_b;
    repeat (BIT) step();
    line = 1'b1;
    repeat (gap) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_data"},  32'(rx_data), 32'h0);
    check({tag, "_rx_valid"}, 32'(rx_valid), 32'h0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'h0);
    check({tag, "_overrun"},  32'(overrun), 32'h0);
    check({tag, "_busy"},     32'(uart_busy), 32'h0);
    check({tag, "_count"},    32'(fifo_count), 32'h0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, f0, p0, s0, nbad_stop, nbad_par, w;
    logic [7:0] b, pkt;
    logic st, pr;

    RST_n = 1'b0; line = 1'b1; rx_ready = 1'b1;
    repeat (3) step();
    check_reset_outputs("reset");
    RST_n = 1'b1;
    repeat (20) step();

    // Single good byte with the consumer always ready.
    v0 = valid_hi_n; f0 = ferr_n;
    send_byte(8'h55, 1'b1, ^8'h55, 40);
    model_frame(8'h55, 1'b1, ^8'h55);
    model_drain();
    check_pops("b55");
    check("b55_valid_cycles", 32'(valid_hi_n - v0), 32'd1);
    check("b55_frame_err", 32'(ferr_n - f0), 32'd0);
    check("b55_busy_len", 32'(busy_len), 32'(BUSY_FRAME));
    check("b55_busy_after", 32'(uart_busy), 32'd0);

    // 40-clock low glitch on an idle line.
    s0 = busy_starts; f0 = ferr_n;
    line = 1'b0;
    repeat (40) step();
    line = 1'b1;
    repeat (2 * BIT) step();
    check("glitch_busy_pulse", 32'(busy_starts - s0), 32'd1);
    check("glitch_busy_len", 32'(busy_len), 32'(BUSY_FALSE));
    check("glitch_busy_after", 32'(uart_busy), 32'd0);
    check("glitch_count", 32'(fifo_count), 32'd0);
    check("glitch_frame_err", 32'(ferr_n - f0), 32'd0);
    check_pops("glitch");

    // Bad stop bit, then recovery.
    f0 = ferr_n;
    send_byte(8'hA3, 1'b0, ^8'hA3, 60);
    model_frame(8'hA3, 1'b0, ^8'hA3);
    check("ferr_pulse_cycles", 32'(ferr_n - f0), 32'd1);
    check("ferr_count", 32'(fifo_count), 32'd0);
    check_pops("ferr_nopush");
    send_byte(8'h11, 1'b1, ^8'h11, 40);
    model_frame(8'h11, 1'b1, ^8'h11);
    model_drain();
    check_pops("after_ferr");

    // Fill the FIFO with the consumer stalled.
    rx_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      b = 8'(k);
      send_byte(b, 1'b1, ^b, 30);
      model_frame(b, 1'b1, ^b);
    end
    check("fill_count", 32'(fifo_count), 32'(mfifo.size()));
    check("fill_overrun", 32'(overrun), 32'(m_ovr));
    check("fill_head", 32'(rx_data), 32'(mfifo[0]));

    // Pop exactly in the cycle the next byte is pushed into the full FIFO.
    fork
      send_byte(8'h08, 1'b1, ^8'h08, 30);
      begin
        w = 0;
        while (uart_busy !== 1'b1 && w < 4 * BIT) begin
          step();
          w++;
        end
        check("pp_busy_start", 32'(uart_busy), 32'd1);
        repeat (BUSY_FRAME - 1) step();
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
      end
    join
    model_pop();
    model_frame(8'h08, 1'b1, ^8'h08);
    check("pp_count", 32'(fifo_count), 32'(mfifo.size()));
    check("pp_overrun", 32'(overrun), 32'd0);
    check("pp_head", 32'(rx_data), 32'(mfifo[0]));

    // One more byte while full and stalled is dropped.
    send_byte(8'h09, 1'b1, ^8'h09, 30);
    model_frame(8'h09, 1'b1, ^8'h09);
    check("ovr_flag", 32'(overrun), 32'(m_ovr));
    check("ovr_count", 32'(fifo_count), 32'd8);
    check("ovr_head", 32'(rx_data), 32'(mfifo[0]));

    rx_ready = 1'b1;
    repeat (20) step();
    model_drain();
    check_pops("drain");
    check("drain_valid", 32'(rx_valid), 32'd0);
    check("drain_count", 32'(fifo_count), 32'd0);
    check("ovr_sticky", 32'(overrun), 32'd1);

    // Reset after data bit 3 of 0x3C.
    pkt = 8'h3C;
    line = 1'b0;
    repeat (BIT) step();
    for (int i = 0; i < 4; i++) begin
      line = pkt[i];
      repeat (BIT) step();
    end
    RST_n = 1'b0;
    step();
    RST_n = 1'b1;
    check_reset_outputs("midreset");
    mfifo.delete();
    m_ovr = 1'b0;
    line = 1'b1;
    repeat (3 * BIT) step();
    check("midreset_count", 32'(fifo_count), 32'd0);
    check("midreset_busy", 32'(uart_busy), 32'd0);
    check_pops("midreset_nopush");
    send_byte(8'h3C, 1'b1, ^8'h3C, 40);
    model_frame(8'h3C, 1'b1, ^8'h3C);
    model_drain();
    check_pops("after_reset");

    // Randomized frames, including bad stops (and bad parity when enabled).
    f0 = ferr_n; p0 = perr_n; nbad_stop = 0; nbad_par = 0;
    for (int k = 0; k < 6; k++) begin
      b  = 8'($urandom);
      st = ($urandom_range(0, 3) != 0);
      pr = (^b) ^ ($urandom_range(0, 3) == 0);
      send_byte(b, st, pr, $urandom_range(20, 200));
      model_frame(b, st, pr);
      if (!st) nbad_stop++;
      if (PB == 1 && (((^b) ^ pr) == 1'b1)) nbad_par++;
    end
    model_drain();
    check_pops("random");
    check("random_frame_err", 32'(ferr_n - f0), 32'(nbad_stop));
    check("random_parity_err", 32'(perr_n - p0), 32'(nbad_par));
    check("random_overrun", 32'(overrun), 32'(m_ovr));

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 needs parity bit 1.
    p0 = perr_n;
    send_byte(8'h07, 1'b1, 1'b0, 40);
    model_frame(8'h07, 1'b1, 1'b0);
    check("par_bad_pulse", 32'(perr_n - p0), 32'd1);
    check_pops("par_bad_nopush");
    p0 = perr_n;
    send_byte(8'h07, 1'b1, 1'b1, 40);
    model_frame(8'h07, 1'b1, 1'b1);
    model_drain();
    check("par_good_nopulse", 32'(perr_n - p0), 32'd0);
    check_pops("par_good");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_framer.md
Name: uart_rx_framer

Overview:
UART receive path, the counterpart to the existing ADC-sample transmit chain. It oversamples the asynchronous rx line, deframes 8N1 characters LSB-first, and flags framing and overrun errors. It buffers received bytes in a small FIFO that downstream control logic drains with a valid/ready handshake. It runs on the system clock RST_clk alongside uart_tx.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BAUD, 115200, line bit rate
OVERSAMPLE, 16, sample ticks per bit (even, >=8)
FIFO_DEPTH, 8, receive FIFO entries (power of 2)

Ports:
RST_clk  in  1  system clock
RST_n  in  1  reset, synchronous, active-low
uart_rx_data  in  1  asynchronous serial line, idle high
rx_data  out  8  FIFO head byte
rx_valid  out  1  FIFO non-empty
rx_ready  in  1  consumer accepts head byte
frame_err  out  1  one-cycle pulse when a bad stop bit is detected
overrun  out  1  sticky: byte dropped because the FIFO was full
uart_busy  out  1  high while a character is being received
fifo_count  out  $clog2(FIFO_DEPTH)+1  bytes held

Behaviour:
- Reset values: rx_data=0, rx_valid=0, frame_err=0, overrun=0, uart_busy=0, fifo_count=0. The synchronizer flops reset to 1 and the FSM resets to IDLE.
- Input path: a 2-FF synchronizer, then a registered copy used for falling-edge detection.
- Tick generator: DIV = round(CLK_HZ/(BAUD*OVERSAMPLE)), minimum 1. A counter runs 0..DIV-1 and emits a one-cycle tick at DIV-1. It is held at 0 in IDLE and restarts at the start edge.
- Sample counter: 0..OVERSAMPLE-1 per bit. The bit value is the majority of the samples at indices M-1, M, M+1, where M=OVERSAMPLE/2.
- FSM:
  - IDLE: on a synchronized 1->0 edge, go to START and set uart_busy=1.
  - START: at the mid-bit decision, majority 1 is a false start and returns to IDLE with uart_busy=0. Majority 0 waits for the end of the bit, then goes to DATA.
  - DATA: shifts 8 bits LSB-first into the shift register. Go to STOP after bit 7 ends.
  - STOP: at the mid-bit decision, value 1 pushes the byte; value 0 pulses frame_err for 1 cycle and discards the byte. Either way the FSM goes to IDLE immediately, with uart_busy=0 from the next cycle. The FSM does not wait for the end of the stop bit, which tolerates -0.5 bit of clock skew.
- After a frame error with the line still low, no new start is detected until the line returns high, because starts are edge-triggered.
- Latency: the byte is visible at rx_data/rx_valid one clock after the STOP decision cycle when the FIFO was empty.
- FIFO: first-word-fall-through. rx_valid = (count!=0) and rx_data = head.
  - Pop on rx_valid&&rx_ready.
  - Push while full without a same-cycle pop: byte dropped, overrun set, count unchanged.
  - Push and pop in the same cycle while full: both happen, count unchanged, no overrun.
  - Push and pop in the same cycle while empty: push only.
  - Pointers wrap modulo FIFO_DEPTH.
- overrun clears only on reset.
- Reset mid-character: all state is discarded on the next clock. A partial byte is never pushed.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined: 8E1 framing. A PARITY state sits between DATA and STOP, and an extra output parity_err (1 bit) pulses for 1 cycle if the XOR of the data bits and the parity bit is 1. A byte with bad parity is not pushed; the frame continues through STOP, where frame_err can also pulse.
- Undefined: 8N1 framing, with no PARITY state and no parity_err port.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP)
  - the DATA_BITS=8 constant
  - the mid-sample index function of OVERSAMPLE
  - the DIV computation function
- Sub-module uart_rx_fifo: a synchronous FWFT FIFO with push, full-drop, overrun, and count logic, parameterized by width and depth.

Test Plan:
All scenarios use CLK_HZ=18432000, BAUD=115200, OVERSAMPLE=16, giving DIV=10 and 160 clocks/bit.
- 0x55, stop=1, rx_ready=1 -> rx_valid high 1 cycle with rx_data=0x55; frame_err=0; uart_busy deasserts after the STOP decision.
- Low glitch of 40 clocks on an idle line -> false start: uart_busy pulses and returns to 0, fifo_count=0, no error.
- 0xA3 with stop=0 -> frame_err 1-cycle pulse, fifo_count stays 0. A following 0x11 sent after the line idles high is received correctly.
- rx_ready=0, send bytes 0x00..0x08 -> fifo_count=8 and overrun=1. Draining yields 0x00..0x07 in order, then rx_valid=0. Pop and push on the same cycle while full -> no overrun, count stays 8.
- Assert RST_n=0 for 1 clock after data bit 3 of 0x3C -> all outputs at reset values the next clock; nothing pushed. A full 0x3C sent afterwards is received correctly.
- UART_RX_PARITY_EN: 0x07 with parity bit 0 -> parity_err pulse, not pushed. 0x07 with parity bit 1 -> pushed, rx_data=0x07.
